// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port between the core load/store path and an
// external bus master (loader / DMA / debug). Round-robin arbitration with an
// optional bounded lock so the external master can issue back-to-back bursts
// without starving the core.
//
// Parameters
//   MAX_LOCK   maximum consecutive locked external grants while the core waits
//   CNT_W      width of the stall performance counter
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   core_rd_en/wr_en/addr/
//   wdata/size                 core load/store request
//   core_stall                 core request present but not granted
//   ext_req/we/lock/addr/
//   wdata/size                 external master request
//   ext_gnt                    external access performed this cycle
//   mem_rd_en/wr_en/addr/
//   wdata/size                 data memory control, driven by the winner
//   mem_rdata                  data memory read data (combinational)
//   rdata                      read data passthrough to both requesters
//   stall_cnt                  saturating count of core stall cycles
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int unsigned MAX_LOCK = 8,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             core_rd_en,
   input  logic             core_wr_en,
   input  logic [31:0]      core_addr,
   input  logic [31:0]      core_wdata,
   input  logic [2:0]       core_size,
   output logic             core_stall,
   input  logic             ext_req,
   input  logic             ext_we,
   input  logic             ext_lock,
   input  logic [31:0]      ext_addr,
   input  logic [31:0]      ext_wdata,
   input  logic [2:0]       ext_size,
   output logic             ext_gnt,
   output logic             mem_rd_en,
   output logic             mem_wr_en,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [2:0]       mem_size,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      rdata,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);

   typedef enum logic {
      ARB      = 1'b0,
      EXT_LOCK = 1'b1
   } state_t;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_EXT  = 1'b1
   } owner_t;

   state_t            state, state_nxt;
   owner_t            last_owner, last_owner_nxt;
   logic [LOCK_W-1:0] lock_cnt, lock_cnt_nxt;

   logic core_req;
   logic core_gnt;
   logic ext_win;
   logic lock_full;

   assign core_req  = core_rd_en | core_wr_en;
   assign lock_full = (lock_cnt >= LOCK_MAX);

   // Grant decision: purely combinational from requests and registered state.
   // Reset suppresses every grant so no access (in particular no write) can
   // happen in a reset cycle.
   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      core_gnt = 1'b0;
      ext_win  = 1'b0;
      if (!reset) begin
         if (core_req && ext_req) begin
            if (state == EXT_LOCK) begin
               // Locked burst: EXT keeps the port until the lock budget is
               // spent, then the core gets one forced slot.
               ext_win  = ~lock_full;
               core_gnt = lock_full;
            end else if (last_owner == OWN_CORE) begin
               ext_win  = 1'b1;
            end else begin
               core_gnt = 1'b1;
            end
         end else begin
            core_gnt = core_req;
            ext_win  = ext_req;
         end
      end
   end

   // Memory port mux. An illegal core rd+wr combination is forwarded as-is.
   always_comb begin
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_size  = '0;
      if (core_gnt) begin
         mem_rd_en = core_rd_en;
         mem_wr_en = core_wr_en;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
         mem_size  = core_size;
      end else if (ext_win) begin
         mem_rd_en = ~ext_we;
         mem_wr_en = ext_we;
         mem_addr  = ext_addr;
         mem_wdata = ext_wdata;
         mem_size  = ext_size;
      end
   end

   assign core_stall = core_req & ~core_gnt & ~reset;
   assign ext_gnt    = ext_win;
   assign rdata      = mem_rdata;

   // Next-state logic for the lock FSM and round-robin pointer.
   always_comb begin
      state_nxt      = state;
      last_owner_nxt = last_owner;
      lock_cnt_nxt   = lock_cnt;

      if (core_gnt) begin
         last_owner_nxt = OWN_CORE;
      end else if (ext_win) begin
         last_owner_nxt = OWN_EXT;
      end

      unique case (state)
         ARB: begin
            if (ext_win && ext_lock) begin
               state_nxt    = EXT_LOCK;
               lock_cnt_nxt = LOCK_W'(1);
            end
         end
         EXT_LOCK: begin
            // Release on request drop, on an unlocked grant, or once the core
            // has taken its forced slot.
            if (!ext_req || (ext_win && !ext_lock) || core_gnt) begin
               state_nxt    = ARB;
               lock_cnt_nxt = '0;
            end else if (ext_win) begin
               // With the core idle the burst may run on; the count simply
               // parks at MAX_LOCK until the core asks for the port.
               lock_cnt_nxt = lock_full ? lock_cnt : lock_cnt + LOCK_W'(1);
            end
         end
         default: begin
            state_nxt    = ARB;
            lock_cnt_nxt = '0;
         end
      endcase
   end

   // last_owner resets to EXT so the core wins the first tie after reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state      <= ARB;
         last_owner <= OWN_EXT;
         lock_cnt   <= '0;
         stall_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         lock_cnt   <= lock_cnt_nxt;
         if (core_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter (MAX_LOCK = 8, CNT_W = 4). Each stimulus
// cycle carries a hand-chosen winner; the stimulus task derives the expected
// memory-port values from it and pushes them into a scoreboard queue. A
// separate monitor pops one entry per cycle on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int unsigned MAX_LOCK = 8;
   localparam int unsigned CNT_W    = 4;

   typedef enum int {W_NONE, W_CORE, W_EXT} win_t;

   typedef struct {
      int          step;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  size;
      logic        stall;
      logic        egnt;
      logic [31:0] rdata;
      logic [3:0]  scnt;
   } exp_t;

   logic             clk;
   logic             reset;
   logic             core_rd_en;
   logic             core_wr_en;
   logic [31:0]      core_addr;
   logic [31:0]      core_wdata;
   logic [2:0]       core_size;
   logic             core_stall;
   logic             ext_req;
   logic             ext_we;
   logic             ext_lock;
   logic [31:0]      ext_addr;
   logic [31:0]      ext_wdata;
   logic [2:0]       ext_size;
   logic             ext_gnt;
   logic             mem_rd_en;
   logic             mem_wr_en;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic [2:0]       mem_size;
   logic [31:0]      mem_rdata;
   logic [31:0]      rdata;
   logic [CNT_W-1:0] stall_cnt;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   step_no = 0;
   logic [3:0] model_cnt = 4'd0;

   dmem_arbiter #(
      .MAX_LOCK(MAX_LOCK),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .core_rd_en (core_rd_en),
      .core_wr_en (core_wr_en),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_size  (core_size),
      .core_stall (core_stall),
      .ext_req    (ext_req),
      .ext_we     (ext_we),
      .ext_lock   (ext_lock),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_size   (ext_size),
      .ext_gnt    (ext_gnt),
      .mem_rd_en  (mem_rd_en),
      .mem_wr_en  (mem_wr_en),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_size   (mem_size),
      .mem_rdata  (mem_rdata),
      .rdata      (rdata),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input int step, input string name,
                        input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL step%0d %s actual=%h required=%h", step, name, act, req);
      end
   endtask

   // One stimulus cycle: drive just after the rising edge, push expectation.
   task automatic cyc(input logic rst,
                      input logic crd, input logic cwr, input logic [31:0] caddr,
                      input logic [31:0] cwdata, input logic [2:0] csize,
                      input logic ereq, input logic ewe, input logic elock,
                      input logic [31:0] eaddr, input logic [31:0] ewdata,
                      input logic [2:0] esize, input win_t w);
      exp_t e;
      @(posedge clk);
      #1;
      reset      = rst;
      core_rd_en = crd;
      core_wr_en = cwr;
      core_addr  = caddr;
      core_wdata = cwdata;
      core_size  = csize;
      ext_req    = ereq;
      ext_we     = ewe;
      ext_lock   = elock;
      ext_addr   = eaddr;
      ext_wdata  = ewdata;
      ext_size   = esize;
      mem_rdata  = 32'hC0DE_0000 | 32'(step_no);

      e.step  = step_no;
      e.rd    = 1'b0;
      e.wr    = 1'b0;
      e.addr  = '0;
      e.wdata = '0;
      e.size  = '0;
      if (w == W_CORE) begin
         e.rd = crd; e.wr = cwr; e.addr = caddr; e.wdata = cwdata; e.size = csize;
      end else if (w == W_EXT) begin
         e.rd = ~ewe; e.wr = ewe; e.addr = eaddr; e.wdata = ewdata; e.size = esize;
      end
      e.stall = (crd | cwr) & (w != W_CORE) & ~rst;
      e.egnt  = (w == W_EXT);
      e.rdata = mem_rdata;
      e.scnt  = model_cnt;
      sb.push_back(e);

      if (rst) model_cnt = 4'd0;
      else if (e.stall && model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
      step_no++;
   endtask

   // Monitor: the DUT presents a response every cycle; compare mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.step, "mem_rd_en",  32'(mem_rd_en),  32'(e.rd));
         check(e.step, "mem_wr_en",  32'(mem_wr_en),  32'(e.wr));
         check(e.step, "mem_addr",   mem_addr,        e.addr);
         check(e.step, "mem_wdata",  mem_wdata,       e.wdata);
         check(e.step, "mem_size",   32'(mem_size),   32'(e.size));
         check(e.step, "core_stall", 32'(core_stall), 32'(e.stall));
         check(e.step, "ext_gnt",    32'(ext_gnt),    32'(e.egnt));
         check(e.step, "rdata",      rdata,           e.rdata);
         check(e.step, "stall_cnt",  32'(stall_cnt),  32'(e.scnt));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      core_rd_en = 1'b0; core_wr_en = 1'b0; core_addr = '0; core_wdata = '0;
      core_size = '0; ext_req = 1'b0; ext_we = 1'b0; ext_lock = 1'b0;
      ext_addr = '0; ext_wdata = '0; ext_size = '0; mem_rdata = '0;
      repeat (2) @(posedge clk);

      // Reset, then a lone core load to 0x100.
      cyc(1, 0,0,32'h0,32'h0,3'd0, 0,0,0,32'h0,32'h0,3'd0, W_NONE);
      cyc(0, 1,0,32'h100,32'h0,3'b010, 0,0,0,32'h0,32'h0,3'd0, W_CORE);
      // Lone external read leaves last_owner = EXT.
      cyc(0, 0,0,32'h0,32'h0,3'd0, 1,0,0,32'h300,32'h0,3'b010, W_EXT);

      // Both request, no lock: CORE, EXT, CORE, EXT.
      for (int i = 0; i < 4; i++)
         cyc(0, 1,0,32'h104 + 32'(4*i),32'h0,3'b010,
             1,0,0,32'h200 + 32'(4*i),32'h0,3'b001, (i % 2) ? W_EXT : W_CORE);

      // Locked EXT burst of 8 against a core store, then the forced core slot.
      cyc(1, 0,0,32'h0,32'h0,3'd0, 0,0,0,32'h0,32'h0,3'd0, W_NONE);
      cyc(0, 1,0,32'h44,32'h0,3'b010, 0,0,0,32'h0,32'h0,3'd0, W_CORE);
      for (int i = 0; i < 9; i++)
         cyc(0, 0,1,32'h40,32'hDEAD_BEEF,3'b010,
             1,1,1,32'h400 + 32'(4*i),32'hA5A5_0000 + 32'(i),3'b010,
             (i < 8) ? W_EXT : W_CORE);
      // Back in ARB with last_owner = CORE: EXT then CORE (stall_cnt shows 8).
      cyc(0, 1,0,32'h48,32'h0,3'b010, 1,0,0,32'h500,32'h0,3'b010, W_EXT);
      cyc(0, 1,0,32'h48,32'h0,3'b010, 1,0,0,32'h500,32'h0,3'b010, W_CORE);

      // Locked burst, ext_req dropped after 3 grants: core granted next cycle.
      for (int i = 0; i < 3; i++)
         cyc(0, 1,0,32'h60,32'h0,3'b010,
             1,1,1,32'h600 + 32'(4*i),32'h1111_0000 + 32'(i),3'b010, W_EXT);
      cyc(0, 1,0,32'h60,32'h0,3'b010, 0,1,1,32'h60C,32'h1111_0003,3'b010, W_CORE);
      cyc(0, 1,0,32'h64,32'h0,3'b010, 1,0,0,32'h700,32'h0,3'b000, W_EXT);
      cyc(0, 1,0,32'h64,32'h0,3'b010, 1,0,0,32'h700,32'h0,3'b000, W_CORE);

      // Reset pulsed on the 5th locked grant: nothing reaches memory.
      for (int i = 0; i < 5; i++)
         cyc((i == 4), 0,1,32'h80,32'h1234_5678,3'b010,
             1,1,1,32'h800 + 32'(4*i),32'h2222_0000 + 32'(i),3'b010,
             (i == 4) ? W_NONE : W_EXT);
      // After reset the core wins the first tie.
      cyc(0, 0,1,32'h80,32'h1234_5678,3'b010, 1,1,1,32'h900,32'h3333_0000,3'b010, W_CORE);
      cyc(0, 0,0,32'h0,32'h0,3'd0, 0,0,0,32'h0,32'h0,3'd0, W_NONE);

      // 40 alternating tie cycles = 20 stalls; 4-bit counter parks at 0xF.
      cyc(1, 0,0,32'h0,32'h0,3'd0, 0,0,0,32'h0,32'h0,3'd0, W_NONE);
      for (int i = 0; i < 40; i++)
         cyc(0, 1,0,32'hA00,32'h0,3'b100,
             1,1,0,32'hB00,32'h5555_0000 + 32'(i),3'b000, (i % 2) ? W_EXT : W_CORE);
      cyc(0, 0,0,32'h0,32'h0,3'd0, 0,0,0,32'h0,32'h0,3'd0, W_NONE);

      repeat (2) @(posedge clk);
      check(step_no, "sb_drained", 32'(sb.size()), 32'd0);
      check(step_no, "stall_cnt_final", 32'(stall_cnt), 32'hF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
